// File: rtl/ex_mdu_if.sv
// Operand/result bundle between the EX stage (id_ex operands, ctrl stall vector)
// and the iterative RV32M multiply/divide unit.
interface ex_mdu_if #(
    parameter int XLEN    = 32,
    parameter int ALU_LEN = 8
);
    logic [5:0]         stall;
    logic [XLEN-1:0]    ex_reg1;
    logic [XLEN-1:0]    ex_reg2;
    logic [ALU_LEN-1:0] ex_alu_op;
    logic [XLEN-1:0]    mdu_result;
    logic               mdu_valid;
    logic               stallreq_mdu;

    modport master (
        output stall, ex_reg1, ex_reg2, ex_alu_op,
        input  mdu_result, mdu_valid, stallreq_mdu
    );

    modport slave (
        input  stall, ex_reg1, ex_reg2, ex_alu_op,
        output mdu_result, mdu_valid, stallreq_mdu
    );
endinterface

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply, restoring divide.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module ex_mdu #(
    parameter int XLEN    = 32,
    parameter int ALU_LEN = 8,
    parameter logic [ALU_LEN-1:0] OP_MUL    = ALU_LEN'('h20),
    parameter logic [ALU_LEN-1:0] OP_MULH   = ALU_LEN'('h21),
    parameter logic [ALU_LEN-1:0] OP_MULHSU = ALU_LEN'('h22),
    parameter logic [ALU_LEN-1:0] OP_MULHU  = ALU_LEN'('h23),
    parameter logic [ALU_LEN-1:0] OP_DIV    = ALU_LEN'('h24),
    parameter logic [ALU_LEN-1:0] OP_DIVU   = ALU_LEN'('h25),
    parameter logic [ALU_LEN-1:0] OP_REM    = ALU_LEN'('h26),
    parameter logic [ALU_LEN-1:0] OP_REMU   = ALU_LEN'('h27)
) (
    input  logic     clk,
    input  logic     rst,
    ex_mdu_if.slave  mdu_bus
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_opnd;
    logic [XLEN-1:0]    r_result;
    logic [ALU_LEN-1:0] r_op;
    logic               r_neg_res;
    logic               r_neg_rem;

    logic [ALU_LEN-1:0] w_op;
    logic [XLEN-1:0]    w_reg1, w_reg2;
    logic               w_is_m, w_is_div, w_s1, w_s2, w_neg1, w_neg2;
    logic [XLEN-1:0]    w_mag1, w_mag2;
    logic               w_div0, w_ovf, w_early;
    logic [XLEN-1:0]    w_early_res;
    logic               w_busy_div, w_last;
    logic [XLEN:0]      w_sum, w_shift, w_diff;
    logic [2*XLEN-1:0]  w_mul_next, w_prod;
    logic [XLEN-1:0]    w_quo_next, w_rem_next, w_quo, w_remf, w_final;

    always_comb begin
        w_op     = mdu_bus.ex_alu_op;
        w_reg1   = mdu_bus.ex_reg1;
        w_reg2   = mdu_bus.ex_reg2;
        w_is_m   = w_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        w_is_div = w_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        w_s1     = w_op inside {OP_DIV, OP_REM, OP_MULH, OP_MULHSU};
        w_s2     = w_op inside {OP_DIV, OP_REM, OP_MULH};
        w_neg1   = w_s1 & w_reg1[XLEN-1];
        w_neg2   = w_s2 & w_reg2[XLEN-1];
        w_mag1   = w_neg1 ? -w_reg1 : w_reg1;
        w_mag2   = w_neg2 ? -w_reg2 : w_reg2;
        w_div0   = w_is_div && (w_reg2 == '0);
        w_ovf    = (w_op inside {OP_DIV, OP_REM}) && (w_reg1 == INT_MIN) && (w_reg2 == '1);
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast;
    always_comb begin
        w_fast = {{XLEN{w_neg1}}, w_reg1} * {{XLEN{w_neg2}}, w_reg2};
    end
`endif

    // Results that never need the iterative datapath are decided in IDLE.
    always_comb begin
        w_early     = w_div0 | w_ovf;
        w_early_res = '0;
        if (w_div0) begin
            w_early_res = (w_op inside {OP_DIV, OP_DIVU}) ? '1 : w_reg1;
        end else if (w_ovf) begin
            w_early_res = (w_op == OP_DIV) ? INT_MIN : '0;
        end
`ifdef MDU_FAST_MUL_EN
        else if (!w_is_div) begin
            w_early     = 1'b1;
            w_early_res = (w_op == OP_MUL) ? w_fast[XLEN-1:0] : w_fast[2*XLEN-1:XLEN];
        end
`endif
    end

    always_comb begin
        w_busy_div = r_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        w_last     = (r_cnt == CW'(XLEN-1));
        w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_mul_next = {w_sum, r_acc[XLEN-1:1]};
        w_shift    = {r_rem, r_acc[XLEN-1]};
        w_diff     = w_shift - {1'b0, r_opnd};
        w_quo_next = {r_acc[XLEN-2:0], ~w_diff[XLEN]};
        w_rem_next = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
        w_prod     = r_neg_res ? -w_mul_next : w_mul_next;
        w_quo      = r_neg_res ? -w_quo_next : w_quo_next;
        w_remf     = r_neg_rem ? -w_rem_next : w_rem_next;
        if (r_op == OP_MUL)                               w_final = w_prod[XLEN-1:0];
        else if (r_op inside {OP_MULH, OP_MULHSU, OP_MULHU}) w_final = w_prod[2*XLEN-1:XLEN];
        else if (r_op inside {OP_DIV, OP_DIVU})           w_final = w_quo;
        else                                              w_final = w_remf;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_is_m) w_next = w_early ? DONE : BUSY;
            BUSY: if (w_last) w_next = DONE;
            DONE: if (!mdu_bus.stall[3]) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mdu_bus.stallreq_mdu = rst && w_is_m && (r_state != DONE);
        mdu_bus.mdu_valid    = (r_state == DONE);
        mdu_bus.mdu_result   = r_result;
    end

    // Multiply keeps the multiplier in the low half of r_acc; divide keeps the
    // shifting dividend/quotient there. r_opnd is the multiplicand or the divisor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_opnd    <= '0;
            r_result  <= '0;
            r_op      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_is_m) begin
                    r_cnt     <= '0;
                    r_op      <= w_op;
                    r_rem     <= '0;
                    r_acc     <= {{XLEN{1'b0}}, w_is_div ? w_mag1 : w_mag2};
                    r_opnd    <= w_is_div ? w_mag2 : w_mag1;
                    r_neg_res <= w_neg1 ^ w_neg2;
                    r_neg_rem <= w_neg1;
                    if (w_early) r_result <= w_early_res;
                end
                BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_acc <= w_busy_div ? {{XLEN{1'b0}}, w_quo_next} : w_mul_next;
                    r_rem <= w_rem_next;
                    if (w_last) r_result <= w_final;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ex_mdu.md
# ex_mdu

Iterative multiply/divide unit for the RV32M extension, located in the EX stage next to the combinational ALU. It reads the operands and ALU op that id_ex presents to ex. For any M-extension op it raises a stall request to ctrl, which freezes the pipeline. It then computes the result over several cycles and presents it for one cycle so that ex can forward it to ex_mem.

## Interface
- XLEN, 32: operand and result width.
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous and active-low; state is cleared immediately while it is low.
- stall  in  6  stall vector from ctrl; stall[3] high means EX is held.
- ex_reg1  in  XLEN  rs1 value from id_ex.
- ex_reg2  in  XLEN  rs2 value from id_ex.
- ex_alu_op  in  `ALU_Len  op from id_ex. New codes `MUL, `MULH, `MULHSU, `MULHU, `DIV, `DIVU, `REM and `REMU are added to config.vh.
- mdu_result  out  XLEN  registered result; valid only while mdu_valid is high.
- mdu_valid  out  1  result-ready strobe; ex selects mdu_result over the ALU output while it is high.
- stallreq_mdu  out  1  stall request to ctrl. ctrl answers with stall[3:0] high.

## Operation
- The unit has three states: IDLE, BUSY and DONE. Define is_m as "ex_alu_op is one of the eight M codes".
- stallreq_mdu = is_m && state != DONE. It is combinational and is forced to 0 while rst is low.
- IDLE, is_m:
  - Latch the operand magnitudes. A signed operand is negated if negative: DIV, REM and MULH use both operands signed, MULHSU uses only rs1 signed, and the remaining ops are unsigned.
  - Latch the result sign, the op, and cnt = 0.
- IDLE, is_m, early-out cases go straight to DONE:
  - Divisor zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (DIV or REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- All other M ops go to BUSY.
- BUSY, divide: restoring radix-2, one quotient bit per cycle, MSB first, using a 33-bit partial remainder.
- BUSY, multiply: shift-add, one multiplier bit per cycle, with a 64-bit accumulator.
- BUSY: cnt increments every cycle. When cnt == 31, apply sign correction and register the result into mdu_result, then go to DONE.
- Sign correction:
  - Product: negate the 64-bit product if the signs differ.
  - Quotient: negate if the signs differ.
  - Remainder: takes the sign of the dividend.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- DONE: mdu_valid = 1.
  - If stall[3] == 0, go to IDLE; ex_mem captures the result on this edge.
  - If stall[3] == 1 (a downstream stall), stay in DONE and hold mdu_result and mdu_valid.
- BUSY ignores stall. The operands are stable because ctrl holds id_ex while stallreq_mdu is high.
- There is no flush input: the instruction in EX is the oldest unresolved instruction.
- Back-to-back M ops: DONE returns to IDLE on the same edge that id_ex loads the next op. That op is detected in the following IDLE cycle.

## Timing
- Reset values: mdu_result = 0, mdu_valid = 0, stallreq_mdu = 0, state = IDLE, cnt = 0.
- Cycle 0 is the first cycle an M op is present. In the iterative case:
  - stallreq_mdu is high in cycles 0..32 (33 cycles).
  - mdu_valid is high in cycle 33.
  - The instruction occupies EX for 34 cycles.
- Early-out: stallreq_mdu is high in cycle 0 only; mdu_valid is high in cycle 1.
- A non-M op never changes state and never stalls.
- Reset asserted mid-BUSY or mid-DONE:
  - The unit returns to IDLE at once and all outputs read 0.
  - The partial result is discarded.
  - After rst is released, the op present is treated as new.

## Configuration
- MDU_FAST_MUL_EN defined: MUL, MULH, MULHSU and MULHU use a single 33x33 signed multiply in IDLE and go directly to DONE. The latency equals the early-out case: 1 stall cycle, with the result in cycle 1. Division stays iterative.
- MDU_FAST_MUL_EN undefined: every multiply uses the 32-cycle shift-add path. No multiplier primitive is inferred.

## Test plan
- MUL with rs1 = 7, rs2 = 0xFFFFFFFD:
  - mdu_result = 0xFFFFFFEB.
  - stallreq_mdu high for 33 cycles (1 with MDU_FAST_MUL_EN).
  - mdu_valid high for exactly 1 cycle.
- rs1 = rs2 = 0xFFFFFFFF: MULHU gives 0xFFFFFFFE; MULH gives 0x00000000; MULHSU gives 0xFFFFFFFF.
- DIV with rs1 = 0xFFFFFFF9 (-7), rs2 = 2: result 0xFFFFFFFD. REM on the same operands: result 0xFFFFFFFF. Both ops issued back-to-back, each taking 34 EX cycles.
- DIVU 5/0 gives 0xFFFFFFFF; REMU 5/0 gives 5. DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM on the same operands gives 0. Each has 1 stall cycle.
- stall[3] held high for 3 cycles during DONE: mdu_valid and mdu_result are held for all 3 cycles, then the unit returns to IDLE on the first edge with stall[3] low.
- rst driven low in BUSY cycle 10 of a DIVU:
  - All outputs read 0 immediately.
  - After release, the same op restarts and produces the correct quotient at cycle 33.
